// File: rtl/dac_ad5668_scheduler.sv
// rtl/dac_ad5668_scheduler.sv - AD5668 update scheduler: shadow registers, power-down and refresh arbitration
//
// Ports:
//   CLK, RST            system clock, synchronous active-high reset
//   wr_en/wr_ch/wr_data host write of one DAC code into a channel shadow register
//   ch_disable          per-channel power-down request (bit n = channel n)
//   dac_cmd_valid/ready frame handshake towards the serial frame shifter
//   dac_cmd_word        32-bit AD5668 frame, MSB first
//   pending             channels whose shadow value has not yet been sent
//   busy                a frame is presented or work remains for an enabled channel

module dac_ad5668_scheduler #(
    parameter int NUM_CH      = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      wr_en,
    input  logic [$clog2(NUM_CH)-1:0] wr_ch,
    input  logic [15:0]               wr_data,
    input  logic [NUM_CH-1:0]         ch_disable,
    output logic                      dac_cmd_valid,
    input  logic                      dac_cmd_ready,
    output logic [31:0]               dac_cmd_word,
    output logic [NUM_CH-1:0]         pending,
    output logic                      busy
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [31:0] REF_FRAME = 32'h0800_0001;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_PWR_UP, S_PWR_DN, S_SEND} state_t;

    state_t            state;
    logic [15:0]       shadow [NUM_CH];
    logic [NUM_CH-1:0] dis_q;
    logic              power_pending;
    logic [CH_W-1:0]   rr_last;
    logic              rewrite_q;
    logic [CW-1:0]     refresh_cnt;

    logic              accept;
    logic              refresh_tc;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] pend_set;
    logic [NUM_CH-1:0] pend_clr;
    logic              rr_found;
    logic [CH_W-1:0]   rr_pick;

    function automatic logic [31:0] ch_frame(input logic [CH_W-1:0] ch, input logic [15:0] data);
        return {4'h0, 4'b0011, {(4-CH_W){1'b0}}, ch, data, 4'h0};
    endfunction

    function automatic logic [31:0] pwr_frame(input logic [1:0] mode, input logic [NUM_CH-1:0] mask);
        return {4'h0, 4'b0100, 14'h0, mode, mask};
    endfunction

    assign accept     = dac_cmd_valid & dac_cmd_ready;
    assign refresh_tc = (REFRESH_DIV != 0) && (refresh_cnt == CW'(REFRESH_DIV - 1));
    assign eligible   = pending & ~dis_q;
    assign busy       = dac_cmd_valid | power_pending | (|eligible);

    // Search starts one past the last channel served so every enabled channel gets a turn.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = rr_last;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!rr_found && eligible[rr_last + CH_W'(k)]) begin
                rr_found = 1'b1;
                rr_pick  = rr_last + CH_W'(k);
            end
        end
    end

    // Sets win over the clear. A write that landed while this channel's frame was
    // already registered (rewrite_q) keeps it pending so the newer code goes out next.
    always_comb begin
        pend_set = refresh_tc ? ~dis_q : '0;
        if (wr_en) begin
            pend_set[wr_ch] = 1'b1;
        end
        pend_clr = '0;
        if (state == S_SEND && accept && !rewrite_q) begin
            pend_clr[rr_last] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= S_INIT;
            dac_cmd_valid <= 1'b0;
            dac_cmd_word  <= '0;
            pending       <= '0;
            dis_q         <= '0;
            power_pending <= 1'b0;
            rr_last       <= CH_W'(NUM_CH - 1);
            rewrite_q     <= 1'b0;
            refresh_cnt   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            dis_q   <= ch_disable;
            pending <= (pending & ~pend_clr) | pend_set;
            if (wr_en) begin
                shadow[wr_ch] <= wr_data;
            end

            // A new disable change re-arms the request even on the edge IDLE consumes it.
            power_pending <= (dis_q != ch_disable) | (power_pending & (state != S_IDLE));

            if (refresh_tc) begin
                refresh_cnt <= '0;
            end else if (REFRESH_DIV != 0) begin
                refresh_cnt <= refresh_cnt + CW'(1);
            end

            case (state)
                S_INIT: begin
                    if (!dac_cmd_valid) begin
                        dac_cmd_valid <= 1'b1;
                        dac_cmd_word  <= REF_FRAME;
                    end else if (dac_cmd_ready) begin
                        dac_cmd_valid <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (power_pending) begin
                        dac_cmd_valid <= 1'b1;
                        if (&dis_q) begin
                            // Nothing to power up: go straight to the power-down frame.
                            dac_cmd_word <= pwr_frame(2'b01, dis_q);
                            state        <= S_PWR_DN;
                        end else begin
                            dac_cmd_word <= pwr_frame(2'b00, ~dis_q);
                            state        <= S_PWR_UP;
                        end
                    end else if (rr_found) begin
                        dac_cmd_valid <= 1'b1;
                        dac_cmd_word  <= ch_frame(rr_pick, shadow[rr_pick]);
                        rr_last       <= rr_pick;
                        rewrite_q     <= wr_en && (wr_ch == rr_pick);
                        state         <= S_SEND;
                    end
                end
                S_PWR_UP: begin
                    if (accept) begin
                        if (dis_q != '0) begin
                            dac_cmd_word <= pwr_frame(2'b01, dis_q);
                            state        <= S_PWR_DN;
                        end else begin
                            dac_cmd_valid <= 1'b0;
                            state         <= S_IDLE;
                        end
                    end
                end
                S_PWR_DN: begin
                    if (accept) begin
                        dac_cmd_valid <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                S_SEND: begin
                    if (wr_en && (wr_ch == rr_last)) begin
                        rewrite_q <= 1'b1;
                    end
                    if (accept) begin
                        dac_cmd_valid <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    dac_cmd_valid <= 1'b0;
                    state         <= S_INIT;
                end
            endcase
        end
    end

endmodule
